// File: rtl/fib_pkg.sv
// Shared widths, owner encoding, FSM states and tag layout for the FIB hash arbiter.
package fib_pkg;

  localparam int PREFIX_W = 64;
  localparam int LEN_W    = 6;
  localparam int HASH_W   = 10;

  typedef enum logic {
    OWN_INS = 1'b0,
    OWN_LKP = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_PAUSED = 2'd2
  } state_e;

  typedef struct packed {
    logic             vld;
    owner_e           owner;
    logic [LEN_W-1:0] len;
  } tag_t;

endpackage

// File: rtl/fib_hash_tag_pipe.sv
// Fixed-depth shift register of {vld,owner,len} tags that tracks in-flight hashes,
// with an occupancy count of the valid stages.
module fib_hash_tag_pipe
  import fib_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  tag_t             push_tag,
  output tag_t             head,
  output logic [CNT_W-1:0] count
);

  tag_t stage [DEPTH];

  assign head = stage[DEPTH-1];

  // NOTE: every stage is reset, not just stage 0 -- stale valid bits would otherwise
  // emit response pulses after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      count <= '0;
    end else begin
      stage[0] <= push ? push_tag : '0;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      // Issue and retire in the same cycle cancel out.
      if (push && !head.vld)      count <= count + CNT_W'(1);
      else if (!push && head.vld) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/fib_hash_arbiter.sv
// Round-robin arbiter sharing the FIB hash unit between the insert and lookup paths,
// with a pause/drain FSM that quiesces the hash unit for table maintenance.
module fib_hash_arbiter
  import fib_pkg::*;
#(
  parameter int HASH_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ins_req,
  input  logic [PREFIX_W-1:0] ins_prefix,
  input  logic [LEN_W-1:0]    ins_len,
  output logic                ins_gnt,
  output logic                ins_rsp_valid,
  input  logic                lkp_req,
  input  logic [PREFIX_W-1:0] lkp_prefix,
  input  logic [LEN_W-1:0]    lkp_len,
  output logic                lkp_gnt,
  output logic                lkp_rsp_valid,
  output logic [HASH_W-1:0]   rsp_hash,
  output logic [LEN_W-1:0]    rsp_len,
  output logic [PREFIX_W-1:0] hash_prefix,
  output logic [LEN_W-1:0]    hash_len,
  input  logic [HASH_W-1:0]   hash_value,
  input  logic                pause_req,
  output logic                paused
);

  localparam int DEPTH = HASH_LAT + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  state_e             state, state_nxt;
  owner_e             rr_last, winner;
  logic               grant_ok, issue;
  logic [LEN_W-1:0]   sel_len;
  tag_t               push_tag, head;
  logic [CNT_W-1:0]   outstanding;

  // Tie goes to whoever did not win last.
  always_comb begin
    winner = OWN_INS;
    if (ins_req && lkp_req) winner = (rr_last == OWN_LKP) ? OWN_INS : OWN_LKP;
    else if (lkp_req)       winner = OWN_LKP;
  end

  // Grants are suppressed while reset is asserted so every output reads 0 during reset.
  assign grant_ok = (state == ST_RUN) && !pause_req && !rst;
  assign ins_gnt  = grant_ok && ins_req && (winner == OWN_INS);
  assign lkp_gnt  = grant_ok && lkp_req && (winner == OWN_LKP);
  assign issue    = ins_gnt || lkp_gnt;
  assign sel_len  = (winner == OWN_INS) ? ins_len : lkp_len;

  always_comb begin
    push_tag       = '0;
    push_tag.vld   = 1'b1;
    push_tag.owner = winner;
    push_tag.len   = sel_len;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last     <= OWN_LKP;
      hash_prefix <= '0;
      hash_len    <= '0;
    end else if (issue) begin
      rr_last     <= winner;
      hash_prefix <= (winner == OWN_INS) ? ins_prefix : lkp_prefix;
      hash_len    <= sel_len;
    end
  end

  fib_hash_tag_pipe #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .push     (issue),
    .push_tag (push_tag),
    .head     (head),
    .count    (outstanding)
  );

  assign ins_rsp_valid = head.vld && (head.owner == OWN_INS);
  assign lkp_rsp_valid = head.vld && (head.owner == OWN_LKP);
  assign rsp_hash      = head.vld ? hash_value : '0;
  assign rsp_len       = head.len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RUN:    if (pause_req) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (!pause_req)              state_nxt = ST_RUN;
        else if (outstanding == '0)  state_nxt = ST_PAUSED;
      end
      ST_PAUSED: if (!pause_req) state_nxt = ST_RUN;
      default:   state_nxt = ST_RUN;
    endcase
  end

  assign paused = (state == ST_PAUSED);

endmodule

// File: tb/tb_fib_hash_arbiter.sv
// Self-checking bench for fib_hash_arbiter: a queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_fib_hash_arbiter;
  import fib_pkg::*;

  localparam int HASH_LAT = 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                ins_req, lkp_req, pause_req;
  logic [PREFIX_W-1:0] ins_prefix, lkp_prefix;
  logic [LEN_W-1:0]    ins_len, lkp_len;
  logic                ins_gnt, lkp_gnt, ins_rsp_valid, lkp_rsp_valid, paused;
  logic [HASH_W-1:0]   rsp_hash, hash_value;
  logic [LEN_W-1:0]    rsp_len, hash_len;
  logic [PREFIX_W-1:0] hash_prefix;

  int n_chk  = 0;
  int n_fail = 0;

  fib_hash_arbiter #(.HASH_LAT(HASH_LAT)) dut (
    .clk           (clk),
    .rst           (rst),
    .ins_req       (ins_req),
    .ins_prefix    (ins_prefix),
    .ins_len       (ins_len),
    .ins_gnt       (ins_gnt),
    .ins_rsp_valid (ins_rsp_valid),
    .lkp_req       (lkp_req),
    .lkp_prefix    (lkp_prefix),
    .lkp_len       (lkp_len),
    .lkp_gnt       (lkp_gnt),
    .lkp_rsp_valid (lkp_rsp_valid),
    .rsp_hash      (rsp_hash),
    .rsp_len       (rsp_len),
    .hash_prefix   (hash_prefix),
    .hash_len      (hash_len),
    .hash_value    (hash_value),
    .pause_req     (pause_req),
    .paused        (paused)
  );

  always #5 clk = ~clk;

  function automatic logic [HASH_W-1:0] hfn(input logic [PREFIX_W-1:0] p, input logic [LEN_W-1:0] l);
    return (p[HASH_W-1:0] ^ p[2*HASH_W-1:HASH_W]) + HASH_W'(l);
  endfunction

  // Stand-in hash unit with a one-cycle latency.
  always @(posedge clk) hash_value <= hfn(hash_prefix, hash_len);

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: in-flight ops as a queue with due cycles.
  typedef struct {
    logic                owner;
    logic [LEN_W-1:0]    len;
    logic [PREFIX_W-1:0] prefix;
    int                  due;
  } op_t;

  op_t                 infl[$];
  int                  cyc = 0;
  logic                m_rr_last = OWN_LKP;
  int                  m_mode = 0;  // 0 running, 1 draining, 2 paused
  logic [PREFIX_W-1:0] m_hp = '0;
  logic [LEN_W-1:0]    m_hl = '0;

  always @(negedge clk) begin
    logic e_ig, e_lg, e_irv, e_lrv, empty;
    logic [HASH_W-1:0] e_hash;
    logic [LEN_W-1:0]  e_len;
    op_t o;
    cyc = cyc + 1;
    if (rst) begin
      infl.delete();
      m_rr_last = OWN_LKP;
      m_mode    = 0;
      m_hp      = '0;
      m_hl      = '0;
      check("reset_outputs",
            128'({ins_gnt, lkp_gnt, ins_rsp_valid, lkp_rsp_valid, rsp_hash, rsp_len,
                  hash_prefix, hash_len, paused}), 128'(0));
    end else begin
      empty = (infl.size() == 0);
      e_irv = 1'b0; e_lrv = 1'b0; e_hash = '0; e_len = '0;
      if (!empty && infl[0].due == cyc) begin
        o      = infl.pop_front();
        e_irv  = (o.owner == OWN_INS);
        e_lrv  = (o.owner == OWN_LKP);
        e_hash = hfn(o.prefix, o.len);
        e_len  = o.len;
      end
      e_ig = 1'b0; e_lg = 1'b0;
      if (m_mode == 0 && !pause_req) begin
        if (ins_req && lkp_req) begin
          if (m_rr_last == OWN_LKP) e_ig = 1'b1;
          else                      e_lg = 1'b1;
        end else begin
          e_ig = ins_req;
          e_lg = lkp_req;
        end
      end
      check("model_grants", 128'({ins_gnt, lkp_gnt}), 128'({e_ig, e_lg}));
      if (e_irv || e_lrv)
        check("model_rsp", 128'({ins_rsp_valid, lkp_rsp_valid, rsp_hash, rsp_len}),
              128'({e_irv, e_lrv, e_hash, e_len}));
      else
        check("model_rsp_idle", 128'({ins_rsp_valid, lkp_rsp_valid}), 128'(0));
      check("model_operands", 128'({hash_prefix, hash_len}), 128'({m_hp, m_hl}));
      check("model_paused", 128'(paused), 128'(m_mode == 2));
      if (e_ig) begin
        infl.push_back('{owner: OWN_INS, len: ins_len, prefix: ins_prefix, due: cyc + 1 + HASH_LAT});
        m_rr_last = OWN_INS; m_hp = ins_prefix; m_hl = ins_len;
      end
      if (e_lg) begin
        infl.push_back('{owner: OWN_LKP, len: lkp_len, prefix: lkp_prefix, due: cyc + 1 + HASH_LAT});
        m_rr_last = OWN_LKP; m_hp = lkp_prefix; m_hl = lkp_len;
      end
      case (m_mode)
        0:       if (pause_req) m_mode = 1;
        1:       if (!pause_req) m_mode = 0; else if (empty) m_mode = 2;
        default: if (!pause_req) m_mode = 0;
      endcase
    end
  end

  task automatic drive_edge();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ni, nl, prev_i;
    logic g_i, g_l;
    rst = 1'b1; ins_req = 1'b0; lkp_req = 1'b0; pause_req = 1'b0;
    ins_prefix = '0; ins_len = '0; lkp_prefix = '0; lkp_len = '0;
    repeat (2) drive_edge();
    rst = 1'b0;
    drive_edge();

    // Contention right after reset: insert wins the first tie.
    ins_req = 1'b1; ins_prefix = 64'h1234; ins_len = 6'd16;
    lkp_req = 1'b1; lkp_prefix = 64'h5678; lkp_len = 6'd20;
    sample(); check("tie_first_ins_gnt", 128'({ins_gnt, lkp_gnt}), 128'(2'b10));
    drive_edge(); ins_req = 1'b0;
    sample(); check("tie_then_lkp_gnt", 128'({ins_gnt, lkp_gnt}), 128'(2'b01));
    drive_edge(); lkp_req = 1'b0;
    sample(); check("tie_ins_rsp", 128'({ins_rsp_valid, lkp_rsp_valid, rsp_len}), 128'({2'b10, 6'd16}));
    drive_edge();
    sample(); check("tie_lkp_rsp", 128'({ins_rsp_valid, lkp_rsp_valid, rsp_len}), 128'({2'b01, 6'd20}));
    repeat (2) drive_edge();

    // Lone insert: hfn(64'hA5, 8) = 10'h0AD.
    ins_req = 1'b1; ins_prefix = 64'hA5; ins_len = 6'd8;
    sample(); check("lone_ins_gnt", 128'(ins_gnt), 128'(1'b1));
    drive_edge(); ins_req = 1'b0;
    sample(); check("lone_no_early_rsp", 128'(ins_rsp_valid), 128'(1'b0));
    drive_edge();
    sample(); check("lone_rsp", 128'({ins_rsp_valid, rsp_len, rsp_hash}), 128'({1'b1, 6'd8, 10'h0AD}));
    repeat (2) drive_edge();

    // Sustained contention: strict alternation, one grant every cycle.
    ni = 0; nl = 0; prev_i = -1;
    ins_req = 1'b1; lkp_req = 1'b1; ins_prefix = 64'h100; lkp_prefix = 64'h200;
    for (int i = 0; i < 10; i++) begin
      sample();
      g_i = ins_gnt; g_l = lkp_gnt;
      ni = ni + int'(g_i);
      nl = nl + int'(g_l);
      check("sustain_one_grant", 128'(g_i ^ g_l), 128'(1'b1));
      if (prev_i >= 0) check("sustain_alternate", 128'(g_i), 128'(prev_i == 0));
      prev_i = int'(g_i);
      drive_edge();
      if (g_i) ins_prefix = ins_prefix + 64'd1;
      if (g_l) lkp_prefix = lkp_prefix + 64'd16;
    end
    ins_req = 1'b0; lkp_req = 1'b0;
    check("sustain_ins_count", 128'(ni), 128'(5));
    check("sustain_lkp_count", 128'(nl), 128'(5));
    repeat (4) drive_edge();

    // Lookup walk: lengths 5,4,3 back to back.
    lkp_req = 1'b1; lkp_prefix = 64'hDEAD_BEEF_0000_0000; lkp_len = 6'd5;
    for (int i = 0; i < 5; i++) begin
      sample();
      if (i < 3) check("walk_gnt", 128'(lkp_gnt), 128'(1'b1));
      if (i >= 2) check("walk_rsp", 128'({lkp_rsp_valid, rsp_len}), 128'({1'b1, 6'(7 - i)}));
      drive_edge();
      if (i < 2) lkp_len = 6'(4 - i);
      else       lkp_req = 1'b0;
    end
    repeat (2) drive_edge();

    // Pause with one insert in flight, lookup pending until release.
    ins_req = 1'b1; ins_prefix = 64'hC0FFEE; ins_len = 6'd12;
    sample(); check("pause_issue_gnt", 128'(ins_gnt), 128'(1'b1));
    drive_edge(); ins_req = 1'b0; pause_req = 1'b1; lkp_req = 1'b1; lkp_len = 6'd24; lkp_prefix = 64'h77;
    sample(); check("pause_first_cycle_no_gnt", 128'({lkp_gnt, paused}), 128'(2'b00));
    drive_edge();
    sample(); check("pause_drain_rsp", 128'({ins_rsp_valid, lkp_gnt, paused}), 128'(3'b100));
    drive_edge();
    sample(); check("pause_drain_empty", 128'({lkp_gnt, paused}), 128'(2'b00));
    drive_edge();
    sample(); check("pause_paused_rises", 128'({lkp_gnt, paused}), 128'(2'b01));
    drive_edge();
    sample(); check("pause_held", 128'({lkp_gnt, paused}), 128'(2'b01));
    drive_edge(); pause_req = 1'b0;
    sample(); check("pause_release_cycle", 128'({lkp_gnt, paused}), 128'(2'b01));
    drive_edge();
    sample(); check("pause_pending_granted", 128'({lkp_gnt, paused}), 128'(2'b10));
    drive_edge(); lkp_req = 1'b0;
    repeat (3) drive_edge();

    // Reset between grant and response; tie afterwards goes to insert again.
    ins_req = 1'b1; ins_prefix = 64'hBAD; ins_len = 6'd33;
    sample(); check("rst_pre_gnt", 128'(ins_gnt), 128'(1'b1));
    drive_edge(); ins_req = 1'b0;
    #2 rst = 1'b1;
    sample();
    check("rst_mid_zero", 128'({ins_gnt, lkp_gnt, ins_rsp_valid, lkp_rsp_valid, rsp_hash, rsp_len,
                                hash_prefix, hash_len, paused}), 128'(0));
    drive_edge(); rst = 1'b0;
    sample(); check("rst_no_rsp", 128'({ins_rsp_valid, lkp_rsp_valid}), 128'(0));
    drive_edge();
    ins_req = 1'b1; lkp_req = 1'b1; ins_prefix = 64'h11; lkp_prefix = 64'h22; ins_len = 6'd1; lkp_len = 6'd2;
    sample(); check("rst_tie_ins", 128'({ins_gnt, lkp_gnt}), 128'(2'b10));
    drive_edge(); ins_req = 1'b0;
    sample(); check("rst_tie_lkp", 128'({ins_gnt, lkp_gnt}), 128'(2'b01));
    drive_edge(); lkp_req = 1'b0;
    repeat (4) drive_edge();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
